data_mem_dbg: RTL and testbench

DATA_MEM_DBG -- requirements
Module: data_mem_dbg

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_lane_align.sv | 47 ++++
 rtl/data_mem_dbg.sv | 158 +++++++++++++++
 tb/tb_data_mem_dbg.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Purpose: shared types and helpers for the data memory with debug port.
// Latency: none (declarations only).
// Backpressure: not applicable.
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // True when a legal access size is not naturally aligned to its address.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_H:    return lo[0];
      SZ_W:    return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Purpose: byte-lane steering for stores (mask + replicated data) and load extraction/extension.
// Latency: purely combinational.
// Backpressure: none; follows the caller's request.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]        i_addr_lo,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [WORD_W-1:0] i_rword,
  output logic [3:0]        o_wmask,
  output logic [WORD_W-1:0] o_wword,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] w_shift;

  // Bring the addressed lane down to bit 0 so extension works the same for every offset.
  assign w_shift = i_rword >> {i_addr_lo, 3'b000};

  // Store data is replicated across lanes so the mask alone selects the target bytes.
  always_comb begin
    o_wmask = 4'b0000;
    o_wword = i_wdata;
    o_rdata = '0;
    case (i_size)
      SZ_B: begin
        o_wmask = 4'b0001 << i_addr_lo;
        o_wword = {4{i_wdata[7:0]}};
        o_rdata = {{24{~i_unsigned & w_shift[7]}}, w_shift[7:0]};
      end
      SZ_H: begin
        o_wmask = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wword = {2{i_wdata[15:0]}};
        o_rdata = {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]};
      end
      SZ_W: begin
        o_wmask = 4'b1111;
        o_wword = i_wdata;
        o_rdata = i_rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_dbg.sv
// Purpose: word-organised data memory with a core port (byte/half/word) and a word-only debug port.
// Latency: one cycle from acceptance to response; stores commit at the accepting edge.
// Backpressure: no acceptance while clearing; core always wins, debug waits for a core-idle cycle.
module data_mem_dbg
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS) + 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        init_done,
  input  logic        core_req_valid,
  input  logic        core_req_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [1:0]  core_size,
  input  logic        core_unsigned,
  output logic        core_ready,
  output logic        core_rsp_valid,
  output logic [31:0] core_rdata,
  output logic        core_err,
  input  logic        dbg_req_valid,
  input  logic        dbg_req_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_req_ready,
  output logic        dbg_rsp_valid,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err
);

  localparam int IW = AW - 2;
  localparam int CW = IW + 1;

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CW-1:0]     r_cnt;

  logic              r_core_rsp_vld;
  logic [WORD_W-1:0] r_core_rdata;
  logic              r_core_err;
  logic              r_dbg_rsp_vld;
  logic [WORD_W-1:0] r_dbg_rdata;
  logic              r_dbg_err;

  logic              w_core_acc;
  logic              w_core_bad;
  logic              w_core_wr;
  logic [IW-1:0]     w_core_idx;
  logic [WORD_W-1:0] w_core_word;
  logic [3:0]        w_wmask;
  logic [WORD_W-1:0] w_wword;
  logic [WORD_W-1:0] w_ld_data;

  logic              w_dbg_acc;
  logic              w_dbg_bad;
  logic              w_dbg_wr;
  logic [IW-1:0]     w_dbg_idx;

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (rst) r_state <= INIT;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; debug only gets the port when the core leaves it free.
  always_comb begin
    w_state_nxt   = r_state;
    core_ready    = 1'b0;
    dbg_req_ready = 1'b0;
    init_done     = 1'b0;
    case (r_state)
      INIT: begin
        if (r_cnt == CW'(DEPTH_WORDS - 1)) w_state_nxt = RUN;
      end
      RUN: begin
        core_ready    = 1'b1;
        dbg_req_ready = ~core_req_valid;
        init_done     = 1'b1;
      end
      default: w_state_nxt = INIT;
    endcase
  end

  // Clear-sweep counter is one bit wider than the index so it parks at DEPTH_WORDS instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst)                  r_cnt <= '0;
    else if (r_state == INIT) r_cnt <= r_cnt + 1'b1;
  end

  assign w_core_acc  = core_req_valid & core_ready;
  assign w_core_idx  = core_addr[AW-1:2];
  assign w_core_bad  = (core_size == 2'b11) | misaligned(core_size, core_addr[1:0])
                     | (|core_addr[31:AW]);
  assign w_core_wr   = w_core_acc & core_req_we & ~w_core_bad;
  assign w_core_word = r_mem[w_core_idx];

  assign w_dbg_acc = dbg_req_valid & dbg_req_ready;
  assign w_dbg_idx = dbg_addr[AW-1:2];
  assign w_dbg_bad = (|dbg_addr[1:0]) | (|dbg_addr[31:AW]);
  assign w_dbg_wr  = w_dbg_acc & dbg_req_we & ~w_dbg_bad;

  dmem_lane_align u_align (
    .i_addr_lo  (core_addr[1:0]),
    .i_size     (core_size),
    .i_unsigned (core_unsigned),
    .i_wdata    (core_wdata),
    .i_rword    (w_core_word),
    .o_wmask    (w_wmask),
    .o_wword    (w_wword),
    .o_rdata    (w_ld_data)
  );

  // Single write port: zero fill during the sweep, then masked core stores or full-word debug stores.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == INIT) begin
        r_mem[r_cnt[IW-1:0]] <= '0;
      end else if (w_core_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (w_wmask[b]) r_mem[w_core_idx][8*b +: 8] <= w_wword[8*b +: 8];
        end
      end else if (w_dbg_wr) begin
        r_mem[w_dbg_idx] <= dbg_wdata;
      end
    end
  end

  // Responses are registered from the pre-edge array, which already holds any store from the prior cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_rsp_vld <= 1'b0;
      r_core_rdata   <= '0;
      r_core_err     <= 1'b0;
      r_dbg_rsp_vld  <= 1'b0;
      r_dbg_rdata    <= '0;
      r_dbg_err      <= 1'b0;
    end else begin
      r_core_rsp_vld <= w_core_acc;
      r_core_rdata   <= (w_core_acc & ~core_req_we & ~w_core_bad) ? w_ld_data : '0;
      r_core_err     <= w_core_acc & w_core_bad;
      r_dbg_rsp_vld  <= w_dbg_acc;
      r_dbg_rdata    <= (w_dbg_acc & ~dbg_req_we & ~w_dbg_bad) ? r_mem[w_dbg_idx] : '0;
      r_dbg_err      <= w_dbg_acc & w_dbg_bad;
    end
  end

  assign core_rsp_valid = r_core_rsp_vld;
  assign core_rdata     = r_core_rdata;
  assign core_err       = r_core_err;
  assign dbg_rsp_valid  = r_dbg_rsp_vld;
  assign dbg_rdata      = r_dbg_rdata;
  assign dbg_err        = r_dbg_err;

endmodule

// File: tb/tb_data_mem_dbg.sv
// Purpose: scoreboard bench for data_mem_dbg; stimulus pushes expected responses, a monitor pops and compares.
// Latency: every response is expected exactly one cycle after its accepting edge.
// Backpressure: bench waits on ready handshakes with bounded loops.
module tb_data_mem_dbg;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        core_req_valid, core_req_we, core_unsigned;
  logic [31:0] core_addr, core_wdata;
  logic [1:0]  core_size;
  logic        core_ready, core_rsp_valid, core_err;
  logic [31:0] core_rdata;
  logic        dbg_req_valid, dbg_req_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_req_ready, dbg_rsp_valid, dbg_err;
  logic [31:0] dbg_rdata;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q_core[$];
  exp_t q_dbg[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_dbg #(.DEPTH_WORDS(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .init_done      (init_done),
    .core_req_valid (core_req_valid),
    .core_req_we    (core_req_we),
    .core_addr      (core_addr),
    .core_wdata     (core_wdata),
    .core_size      (core_size),
    .core_unsigned  (core_unsigned),
    .core_ready     (core_ready),
    .core_rsp_valid (core_rsp_valid),
    .core_rdata     (core_rdata),
    .core_err       (core_err),
    .dbg_req_valid  (dbg_req_valid),
    .dbg_req_we     (dbg_req_we),
    .dbg_addr       (dbg_addr),
    .dbg_wdata      (dbg_wdata),
    .dbg_req_ready  (dbg_req_ready),
    .dbg_rsp_valid  (dbg_rsp_valid),
    .dbg_rdata      (dbg_rdata),
    .dbg_err        (dbg_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: on each falling edge, pop and compare any presented response; idle outputs must be zero.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (core_rsp_valid === 1'b1) begin
        if (q_core.size() == 0) begin
          chk("core unexpected rsp_valid", 32'd1, 32'd0);
        end else begin
          e = q_core.pop_front();
          chk("core rsp latency", cyc, e.cyc);
          chk("core rdata", core_rdata, e.data);
          chk("core err", {31'd0, core_err}, {31'd0, e.err});
        end
      end else begin
        chk("core idle rdata", core_rdata, 32'd0);
        chk("core idle err", {31'd0, core_err}, 32'd0);
      end
      if (dbg_rsp_valid === 1'b1) begin
        if (q_dbg.size() == 0) begin
          chk("dbg unexpected rsp_valid", 32'd1, 32'd0);
        end else begin
          e = q_dbg.pop_front();
          chk("dbg rsp latency", cyc, e.cyc);
          chk("dbg rdata", dbg_rdata, e.data);
          chk("dbg err", {31'd0, dbg_err}, {31'd0, e.err});
        end
      end else begin
        chk("dbg idle rdata", dbg_rdata, 32'd0);
        chk("dbg idle err", {31'd0, dbg_err}, 32'd0);
      end
    end
  end

  task automatic core_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns,
                          input logic exp_err, input logic [31:0] exp_d);
    exp_t e;
    core_req_valid = 1'b1;
    core_req_we    = we;
    core_addr      = addr;
    core_wdata     = wd;
    core_size      = sz;
    core_unsigned  = uns;
    chk("core_ready in RUN", {31'd0, core_ready}, 32'd1);
    e.err = exp_err;
    e.data = exp_d;
    e.cyc = cyc + 1;
    q_core.push_back(e);
    @(posedge clk); #1;
    core_req_valid = 1'b0;
  endtask

  task automatic dbg_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_d);
    exp_t e;
    dbg_req_valid = 1'b1;
    dbg_req_we    = we;
    dbg_addr      = addr;
    dbg_wdata     = wd;
    #1;
    chk("dbg_req_ready core idle", {31'd0, dbg_req_ready}, 32'd1);
    e.err = exp_err;
    e.data = exp_d;
    e.cyc = cyc + 1;
    q_dbg.push_back(e);
    @(posedge clk); #1;
    dbg_req_valid = 1'b0;
  endtask

  // Count edges from reset release until init_done; optionally poke both ports while clearing.
  task automatic wait_init(input bit poke);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < DEPTH + 20) begin
      if (poke && n == 2) begin
        core_req_valid = 1'b1; core_req_we = 1'b1; core_addr = 32'h0;
        core_wdata = 32'hFFFF_FFFF; core_size = 2'b10;
        dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_addr = 32'h4; dbg_wdata = 32'hFFFF_FFFF;
        #1;
        chk("init core_ready", {31'd0, core_ready}, 32'd0);
        chk("init dbg_req_ready", {31'd0, dbg_req_ready}, 32'd0);
      end
      if (n == 5) begin
        core_req_valid = 1'b0;
        dbg_req_valid  = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    core_req_valid = 1'b0;
    dbg_req_valid  = 1'b0;
    chk("init sweep cycles", n, DEPTH);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    core_req_valid = 1'b0; core_req_we = 1'b0; core_addr = '0; core_wdata = '0;
    core_size = 2'b10; core_unsigned = 1'b0;
    dbg_req_valid = 1'b0; dbg_req_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    @(posedge clk); #1;
    chk("reset init_done", {31'd0, init_done}, 32'd0);
    chk("reset core_ready", {31'd0, core_ready}, 32'd0);
    chk("reset dbg_req_ready", {31'd0, dbg_req_ready}, 32'd0);
    chk("reset core_rsp_valid", {31'd0, core_rsp_valid}, 32'd0);
    chk("reset dbg_rsp_valid", {31'd0, dbg_rsp_valid}, 32'd0);
    rst = 1'b0;
    wait_init(1'b1);

    // Every word reads zero after the sweep, including those poked during INIT.
    for (int i = 0; i < DEPTH; i++) core_req(1'b0, 32'(4 * i), 32'h0, 2'b10, 1'b0, 1'b0, 32'h0);

    // Word store then sub-word loads with sign/zero extension.
    core_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 32'h0);
    core_req(1'b0, 32'h13, 32'h0,        2'b00, 1'b0, 1'b0, 32'hFFFFFFDE);
    core_req(1'b0, 32'h12, 32'h0,        2'b01, 1'b1, 1'b0, 32'h0000DEAD);
    core_req(1'b0, 32'h10, 32'h0,        2'b00, 1'b1, 1'b0, 32'h000000EF);
    core_req(1'b0, 32'h10, 32'h0,        2'b01, 1'b0, 1'b0, 32'hFFFFBEEF);
    core_req(1'b0, 32'h10, 32'h0,        2'b10, 1'b1, 1'b0, 32'hDEADBEEF);

    // Byte store immediately followed by a word load of the same word.
    core_req(1'b1, 32'h21, 32'h0000005A, 2'b00, 1'b0, 1'b0, 32'h0);
    core_req(1'b0, 32'h20, 32'h0,        2'b10, 1'b0, 1'b0, 32'h00005A00);

    // Faults: misaligned, out of range, illegal size; memory must stay intact.
    core_req(1'b0, 32'h22, 32'h0,        2'b10, 1'b0, 1'b1, 32'h0);
    core_req(1'b0, 32'(4 * DEPTH), 32'h0, 2'b10, 1'b0, 1'b1, 32'h0);
    core_req(1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 2'b10, 1'b0, 1'b1, 32'h0);
    core_req(1'b1, 32'h11, 32'h0000FFFF, 2'b01, 1'b0, 1'b1, 32'h0);
    core_req(1'b0, 32'h10, 32'h0,        2'b11, 1'b0, 1'b1, 32'h0);
    core_req(1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 1'b0, 32'hDEADBEEF);
    core_req(1'b0, 32'h00, 32'h0,        2'b10, 1'b0, 1'b0, 32'h0);

    // Simultaneous requests: core wins, debug store goes in the next core-idle cycle.
    core_req_valid = 1'b1; core_req_we = 1'b0; core_addr = 32'h10; core_size = 2'b10; core_unsigned = 1'b0;
    dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_addr = 32'h24; dbg_wdata = 32'h12345678;
    #1;
    chk("arb dbg_req_ready under core", {31'd0, dbg_req_ready}, 32'd0);
    e.err = 1'b0; e.data = 32'hDEADBEEF; e.cyc = cyc + 1;
    q_core.push_back(e);
    @(posedge clk); #1;
    core_req_valid = 1'b0;
    dbg_req(1'b1, 32'h24, 32'h12345678, 1'b0, 32'h0);

    dbg_req(1'b0, 32'h24, 32'h0, 1'b0, 32'h12345678);
    core_req(1'b0, 32'h24, 32'h0, 2'b10, 1'b0, 1'b0, 32'h12345678);
    dbg_req(1'b0, 32'h26, 32'h0, 1'b1, 32'h0);
    dbg_req(1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 1'b1, 32'h0);
    core_req(1'b0, 32'h00, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a store stream drops the pending response and reclears memory.
    core_req(1'b1, 32'h30, 32'hAAAA5555, 2'b10, 1'b0, 1'b0, 32'h0);
    core_req(1'b1, 32'h34, 32'h5555AAAA, 2'b10, 1'b0, 1'b0, 32'h0);
    core_req_valid = 1'b1; core_req_we = 1'b1; core_addr = 32'h38; core_wdata = 32'h0BADF00D;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid-run reset rsp_valid", {31'd0, core_rsp_valid}, 32'd0);
    chk("mid-run reset init_done", {31'd0, init_done}, 32'd0);
    rst = 1'b0;
    core_req_valid = 1'b0;
    wait_init(1'b0);
    core_req(1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0);
    core_req(1'b0, 32'h34, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0);
    core_req(1'b0, 32'h38, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0);
    core_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0);
    core_req(1'b0, 32'h24, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("core scoreboard drained", q_core.size(), 32'd0);
    chk("dbg scoreboard drained", q_dbg.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
